// File: rtl/universal_shiftreg.sv
// rtl/universal_shiftreg.sv - parametrised universal shift register with burst step engine
module universal_shiftreg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             din_r,
  input  logic             din_l,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               start_ok;

  // One step of the selected operation applied to the current contents
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             dr,
    input logic             dl,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      M_HOLD: res = cur;
      M_SHR:  res = {dr, cur[WIDTH-1:1]};
      M_SHL:  res = {cur[WIDTH-2:0], dl};
      M_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      M_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_LOAD: res = ld;
      M_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only shift/rotate modes make sense repeated; hold/load/clear bursts are rejected
  function automatic logic is_burst_mode(input logic [2:0] op);
    return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
           (op == M_ROL) || (op == M_ASR);
  endfunction

  assign start_ok = start && is_burst_mode(mode);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state: accepted start enters RUN (or straight to DONE for a zero-length burst)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (rem_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: single steps in IDLE, latched-mode steps in RUN
  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    rem_d  = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          mode_d = mode;
          rem_d  = count;
        end else if (en) begin
          q_d = step_fn(mode, q_q, din_r, din_l, pdata);
        end
      end
      S_RUN: begin
        // Serial inputs are sampled live on every burst step
        q_d   = step_fn(mode_q, q_q, din_r, din_l, pdata);
        rem_d = rem_q - CNT_W'(1);
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shiftreg.sv
// tb/tb_universal_shiftreg.sv - self-checking bench for universal_shiftreg
module tb_universal_shiftreg;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic [2:0] mode;
  logic       din_r;
  logic       din_l;
  logic [7:0] pdata;
  logic       start;
  logic [3:0] count;

  logic [7:0] q8;
  logic       sout_r8, sout_l8, busy8, done8;
  logic [3:0] q4;
  logic       sout_r4, sout_l4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (8-bit instance)
  int m_q, m_left, m_mode;
  bit m_busy, m_done;

  universal_shiftreg #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .din_r(din_r), .din_l(din_l),
    .pdata(pdata), .start(start), .count(count), .q(q8), .sout_r(sout_r8),
    .sout_l(sout_l8), .busy(busy8), .done(done8)
  );

  universal_shiftreg #(.WIDTH(4), .CNT_W(4)) u4 (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .din_r(din_r), .din_l(din_l),
    .pdata(pdata[3:0]), .start(start), .count(count), .q(q4), .sout_r(sout_r4),
    .sout_l(sout_l4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_step(int op, int cur, int dr, int dl, int pd);
    case (op)
      1: return (cur >> 1) | (dr << 7);
      2: return ((cur << 1) & 255) | dl;
      3: return (cur >> 1) | ((cur & 1) << 7);
      4: return ((cur << 1) & 255) | (cur >> 7);
      5: return pd;
      6: return (cur >> 1) | (cur & 128);
      7: return 0;
      default: return cur;
    endcase
  endfunction

  task automatic model_edge();
    if (m_busy) begin
      m_q = m_step(m_mode, m_q, int'(din_r), int'(din_l), int'(pdata));
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start && (mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6})) begin
      m_mode = int'(mode);
      if (count == 4'd0) m_done = 1;
      else begin
        m_left = int'(count);
        m_busy = 1;
      end
    end else if (en) begin
      m_q = m_step(int'(mode), m_q, int'(din_r), int'(din_l), int'(pdata));
    end
  endtask

  task automatic load8(input logic [7:0] v);
    en = 1'b1; mode = 3'b101; pdata = v; start = 1'b0;
    clk_step();
    en = 1'b0; mode = 3'b000;
    n_checks++;
    if (q8 !== v) begin n_fail++; $display("FAIL load q=%h exp=%h", q8, v); end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; en = 1'b1; mode = 3'b101; pdata = 8'hFF; start = 1'b1; count = 4'd3;
    din_r = 1'b0; din_l = 1'b0;
    clk_step();
    clk_step();
    n_checks++;
    if (q8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_held q=%h busy=%b done=%b exp 00/0/0", q8, busy8, done8);
    end
    n_checks++;
    if (q4 !== 4'h0) begin n_fail++; $display("FAIL reset_held_w4 q=%h exp=0", q4); end
    clr_n = 1'b1; start = 1'b0;
    clk_step();
    en = 1'b0;
    n_checks++;
    if (q8 !== 8'hFF) begin n_fail++; $display("FAIL reset_preload q=%h exp=ff", q8); end
    #3;
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (q8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0 || q4 !== 4'h0) begin
      n_fail++; $display("FAIL reset_async q=%h q4=%h busy=%b done=%b exp 00/0/0/0", q8, q4, busy8, done8);
    end
    #1;
    clr_n = 1'b1;
    clk_step();
  endtask

  task automatic test_shr_w4();
    logic [3:0] seq;
    logic [3:0] exp4 [4];
    seq = 4'b1001;
    exp4[0] = 4'b1000; exp4[1] = 4'b0100; exp4[2] = 4'b0010; exp4[3] = 4'b1001;
    en = 1'b1; mode = 3'b001; din_l = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_r = seq[3-i];
      clk_step();
      n_checks++;
      if (q4 !== exp4[i] || sout_r4 !== exp4[i][0] || sout_l4 !== exp4[i][3]) begin
        n_fail++; $display("FAIL shr_w4 step %0d q=%b sout_r=%b exp=%b", i, q4, sout_r4, exp4[i]);
      end
    end
    en = 1'b0; din_r = 1'b0;
  endtask

  task automatic test_rol_burst();
    logic [7:0] exp8 [3];
    exp8[0] = 8'h4B; exp8[1] = 8'h96; exp8[2] = 8'h2D;
    load8(8'hA5);
    start = 1'b1; mode = 3'b100; count = 4'd3;
    clk_step();
    start = 1'b0; mode = 3'b000; count = 4'd0;
    n_checks++;
    if (q8 !== 8'hA5 || busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL rol_accept q=%h busy=%b done=%b exp a5/1/0", q8, busy8, done8);
    end
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if (q8 !== exp8[i] || busy8 !== (i < 2) || done8 !== (i == 2)) begin
        n_fail++; $display("FAIL rol_step %0d q=%h busy=%b done=%b exp q=%h", i, q8, busy8, done8, exp8[i]);
      end
    end
    clk_step();
    n_checks++;
    if (q8 !== 8'h2D || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL rol_after q=%h busy=%b done=%b exp 2d/0/0", q8, busy8, done8);
    end
  endtask

  task automatic test_asr_zero_count();
    load8(8'h80);
    start = 1'b1; mode = 3'b110; count = 4'd3;
    clk_step();
    start = 1'b0;
    repeat (3) clk_step();
    n_checks++;
    if (q8 !== 8'hF0 || done8 !== 1'b1) begin
      n_fail++; $display("FAIL asr_burst q=%h done=%b exp f0/1", q8, done8);
    end
    clk_step();
    start = 1'b1; mode = 3'b110; count = 4'd0;
    clk_step();
    start = 1'b0; mode = 3'b000;
    n_checks++;
    if (q8 !== 8'hF0 || done8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL zero_count q=%h done=%b busy=%b exp f0/1/0", q8, done8, busy8);
    end
    clk_step();
    n_checks++;
    if (q8 !== 8'hF0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL zero_count_after q=%h done=%b exp f0/0", q8, done8);
    end
  endtask

  task automatic test_start_during_run();
    logic [7:0] exp8 [4];
    exp8[0] = 8'h1E; exp8[1] = 8'h0F; exp8[2] = 8'h87; exp8[3] = 8'hC3;
    load8(8'h3C);
    start = 1'b1; mode = 3'b011; count = 4'd4;
    clk_step();
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; count = 4'($urandom_range(1, 15)); en = i[0];
      mode = 3'b101; pdata = 8'h00; din_r = 1'b1; din_l = 1'b1;
      clk_step();
      n_checks++;
      if (q8 !== exp8[i] || done8 !== (i == 3)) begin
        n_fail++; $display("FAIL run_ignore step %0d q=%h done=%b exp=%h", i, q8, done8, exp8[i]);
      end
    end
    start = 1'b1; en = 1'b1; mode = 3'b001; count = 4'd2;
    clk_step();
    start = 1'b0; en = 1'b0; mode = 3'b000;
    n_checks++;
    if (q8 !== 8'hC3 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL done_ignore q=%h busy=%b done=%b exp c3/0/0", q8, busy8, done8);
    end
  endtask

  task automatic test_reset_mid_burst();
    load8(8'h01);
    start = 1'b1; mode = 3'b010; count = 4'd5; din_l = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    clk_step();
    n_checks++;
    if (q8 !== 8'h07 || busy8 !== 1'b1) begin
      n_fail++; $display("FAIL mid_step2 q=%h busy=%b exp 07/1", q8, busy8);
    end
    #3;
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (q8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset q=%h busy=%b done=%b exp 00/0/0", q8, busy8, done8);
    end
    clk_step();
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clk_step();
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || q8 !== 8'h00) begin
        n_fail++; $display("FAIL mid_no_done cyc %0d q=%h busy=%b done=%b exp 00/0/0", i, q8, busy8, done8);
      end
    end
    start = 1'b1; mode = 3'b010; count = 4'd2; din_l = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    clk_step();
    n_checks++;
    if (q8 !== 8'h03 || done8 !== 1'b1) begin
      n_fail++; $display("FAIL fresh_burst q=%h done=%b exp 03/1", q8, done8);
    end
    clk_step();
  endtask

  task automatic test_random();
    clr_n = 1'b0; start = 1'b0; en = 1'b0;
    clk_step();
    clr_n = 1'b1;
    m_q = 0; m_left = 0; m_mode = 0; m_busy = 0; m_done = 0;
    for (int i = 0; i < 400; i++) begin
      en    = 1'($urandom_range(0, 1));
      mode  = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 4) == 0);
      count = 4'($urandom_range(0, 6));
      din_r = 1'($urandom_range(0, 1));
      din_l = 1'($urandom_range(0, 1));
      pdata = 8'($urandom);
      model_edge();
      clk_step();
      n_checks++;
      if (q8 !== 8'(m_q) || busy8 !== m_busy || done8 !== m_done ||
          sout_r8 !== 1'(m_q & 1) || sout_l8 !== 1'(m_q >> 7)) begin
        n_fail++;
        $display("FAIL random cyc %0d q=%h busy=%b done=%b exp q=%h busy=%b done=%b",
                 i, q8, busy8, done8, 8'(m_q), m_busy, m_done);
      end
    end
    start = 1'b0; en = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; mode = 3'b000; din_r = 1'b0; din_l = 1'b0;
    pdata = 8'h00; start = 1'b0; count = 4'd0;
    test_reset();
    test_shr_w4();
    test_rol_burst();
    test_asr_zero_count();
    test_start_during_run();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
